issue_scoreboard: RTL and testbench
===================================

// Module: issue_scoreboard
// PURPOSE
//  Issue stage directly upstream of register_file. Accepts decoded instructions
//   (rs1, rs2, rd, wr_en) from decode, checks them against a per-register
//   pending-write scoreboard, and issues them one per cycle into an output slot.
//  The slot drives register_file read_reg1/read_reg2 and execute. Writeback
//   (wb_valid/wb_reg, same as register_file write port) retires pending writes.
// PARAMETERS
//  ID_LENGTH    2  register index width; NUM_REGS = 2**ID_LENGTH
//  MAX_PENDING  3  max outstanding (issued, not written back) writes; 1..NUM_REGS
// PORTS
//  clk        in   1          clock, all state on rising edge
//  rst        in   1          asynchronous reset, active-low
//  in_valid   in   1          decode offers an instruction
//  in_ready   out  1          stage accepts it this cycle
//  in_rs1     in   ID_LENGTH  source 1 index
//  in_rs2     in   ID_LENGTH  source 2 index
//  in_rd      in   ID_LENGTH  destination index
//  in_wr_en   in   1          instruction writes in_rd
//  out_valid  out  1          output slot holds an issued instruction
//  out_ready  in   1          execute consumes the slot
//  read_reg1  out  ID_LENGTH  to register_file read_reg1 (slot rs1)
//  read_reg2  out  ID_LENGTH  to register_file read_reg2 (slot rs2)
//  out_rd     out  ID_LENGTH  slot destination
//  out_wr_en  out  1          slot write enable
//  wb_valid   in   1          writeback retires a write this cycle
//  wb_reg     in   ID_LENGTH  register being written back
//  flush      in   1          kill the instruction in the output slot
//  pending    out  NUM_REGS   scoreboard bit per register
//  inflight   out  $clog2(MAX_PENDING+1)  count of set pending bits
//  wb_err     out  1          sticky: illegal writeback seen
// BEHAVIOUR
//  Reset (rst=0, async): out_valid=0, read_reg1/2=0, out_rd=0, out_wr_en=0,
//   pending=0, inflight=0, wb_err=0. Deassertion takes effect at next edge.
//  clr = wb_valid & pending[wb_reg] ? onehot(wb_reg) : 0; eff = pending & ~clr
//   (same-cycle writeback bypass into hazard check).
//  hazard = eff[in_rs1] | eff[in_rs2] | in_wr_en&(eff[in_rd] | inflight-|clr|==MAX_PENDING).
//  in_ready = (!out_valid | out_ready) & !hazard & !flush (combinational).
//  Accept = in_valid & in_ready: slot loads in_* next edge, out_valid=1;
//   if in_wr_en, pending[in_rd] set. Latency 1 cycle from accept to out_valid.
//  Slot consumed (out_valid & out_ready) without accept: out_valid->0; slot
//   fields hold last values.
//  Stall: slot unchanged while out_valid & !out_ready.
//  Writeback: clears pending[wb_reg] if set; if not set, ignored, wb_err->1.
//  Set and clear of same register in one cycle: set wins (bit stays 1).
//  flush: out_valid->0; if slot was valid with out_wr_en, pending[out_rd]
//   cleared (write never happens). No accept that cycle. Flush on empty slot: no-op.
//   flush+wb same reg as out_rd: single clear, wb_err->1.
//  inflight always equals popcount(pending); +1 per set, -1 per clear, net 0
//   when both; never exceeds MAX_PENDING, never underflows.
//  One pending bit per register max (WAW stalls); no register is hardwired.
// TESTING
//  After reset: pending=0, inflight=0, out_valid=0, in_ready=1 with out_ready=1.
//  Issue rd=1 wr; next: rs1=1 -> in_ready=0 until wb_valid,wb_reg=1, then same-
//   cycle accept (bypass), pending=4'b0000 after writeback edge (no new write).
//  MAX_PENDING=3: issue writes to r0,r1,r2 -> inflight=3; write to r3 stalls;
//   wb r0 same cycle -> accepted, inflight stays 3.
//  out_ready=0 for 5 cycles: slot and read_reg1/2 stable, in_ready=0; release ->
//   next instruction appears 1 cycle later.
//  Slot holds wr rd=2, flush=1 -> out_valid=0, pending[2]=0, inflight-1;
//   wb_valid,wb_reg=3 with pending[3]=0 -> wb_err=1, remains 1 until reset.
//  Assert rst=0 mid-stall with pending=4'b0110 -> all outputs zero immediately.

Source files
------------

// File: rtl/issue_scoreboard.sv
// Issue stage with a per-register pending-write scoreboard.
// Decoded instructions are checked for RAW/WAW hazards against outstanding
// writes and issued one per cycle into a single output slot, which feeds
// the register_file read ports and execute. Writeback retires pending writes.
module issue_scoreboard #(
  parameter  int ID_LENGTH   = 2,
  parameter  int MAX_PENDING = 3,
  localparam int NUM_REGS    = 2**ID_LENGTH,
  localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ID_LENGTH-1:0] in_rs1,
  input  logic [ID_LENGTH-1:0] in_rs2,
  input  logic [ID_LENGTH-1:0] in_rd,
  input  logic                 in_wr_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ID_LENGTH-1:0] read_reg1,
  output logic [ID_LENGTH-1:0] read_reg2,
  output logic [ID_LENGTH-1:0] out_rd,
  output logic                 out_wr_en,
  input  logic                 wb_valid,
  input  logic [ID_LENGTH-1:0] wb_reg,
  input  logic                 flush,
  output logic [NUM_REGS-1:0]  pending,
  output logic [CNT_W-1:0]     inflight,
  output logic                 wb_err
);

  logic                 r_out_valid;
  logic [ID_LENGTH-1:0] r_rs1;
  logic [ID_LENGTH-1:0] r_rs2;
  logic [ID_LENGTH-1:0] r_rd;
  logic                 r_wr_en;
  logic [NUM_REGS-1:0]  r_pending;
  logic [CNT_W-1:0]     r_inflight;
  logic                 r_wb_err;

  logic [NUM_REGS-1:0]  w_clr;
  logic [NUM_REGS-1:0]  w_fclr;
  logic [NUM_REGS-1:0]  w_set;
  logic [NUM_REGS-1:0]  w_eff;
  logic [NUM_REGS-1:0]  w_pending_nxt;
  logic [CNT_W-1:0]     w_cnt_adj;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 w_full;
  logic                 w_hazard;
  logic                 w_accept;
  logic                 w_wb_illegal;

  // Writeback clear, flush clear and issue set vectors, plus hazard check
  // using the post-writeback view of the scoreboard.
  always_comb begin
    w_clr  = '0;
    w_fclr = '0;
    w_set  = '0;
    if (wb_valid && r_pending[wb_reg])
      w_clr[wb_reg] = 1'b1;
    if (flush && r_out_valid && r_wr_en)
      w_fclr[r_rd] = 1'b1;
    w_eff     = r_pending & ~w_clr;
    w_cnt_adj = r_inflight - CNT_W'(|w_clr);
    w_full    = (w_cnt_adj == CNT_W'(MAX_PENDING));
    w_hazard  = w_eff[in_rs1] | w_eff[in_rs2] |
                (in_wr_en & (w_eff[in_rd] | w_full));
    in_ready  = (~r_out_valid | out_ready) & ~w_hazard & ~flush;
    w_accept  = in_valid & in_ready;
    if (w_accept && in_wr_en)
      w_set[in_rd] = 1'b1;
    // A writeback racing a flush of the same register is treated as illegal:
    // the flushed write never happens, so nothing legitimate is retired.
    w_wb_illegal  = wb_valid & (~r_pending[wb_reg] | w_fclr[wb_reg]);
    w_pending_nxt = (r_pending & ~w_clr & ~w_fclr) | w_set;
  end

  // Inflight tracks popcount of the next scoreboard state.
  always_comb begin
    w_cnt_nxt = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      w_cnt_nxt = w_cnt_nxt + CNT_W'(w_pending_nxt[i]);
  end

  // Output slot: load on accept, drop on flush or consume, hold on stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_wr_en     <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_rs1       <= in_rs1;
      r_rs2       <= in_rs2;
      r_rd        <= in_rd;
      r_wr_en     <= in_wr_en;
    end else if (flush || (r_out_valid && out_ready)) begin
      r_out_valid <= 1'b0;
    end
  end

  // Scoreboard state, inflight count and sticky writeback error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending  <= '0;
      r_inflight <= '0;
      r_wb_err   <= 1'b0;
    end else begin
      r_pending  <= w_pending_nxt;
      r_inflight <= w_cnt_nxt;
      if (w_wb_illegal)
        r_wb_err <= 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign read_reg1 = r_rs1;
  assign read_reg2 = r_rs2;
  assign out_rd    = r_rd;
  assign out_wr_en = r_wr_en;
  assign pending   = r_pending;
  assign inflight  = r_inflight;
  assign wb_err    = r_wb_err;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: a scoreboard queue tracks issued
// instructions and checks slot contents when execute consumes them; scenario
// tasks check scoreboard, handshake and error behaviour against constants.
module tb_issue_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [1:0] in_rs1, in_rs2, in_rd;
  logic       in_wr_en;
  logic       out_valid, out_ready;
  logic [1:0] read_reg1, read_reg2, out_rd;
  logic       out_wr_en;
  logic       wb_valid;
  logic [1:0] wb_reg;
  logic       flush;
  logic [3:0] pending;
  logic [1:0] inflight;
  logic       wb_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] sb_q[$];
  logic [6:0] exp_item;

  issue_scoreboard #(.ID_LENGTH(2), .MAX_PENDING(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wr_en(in_wr_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .out_rd(out_rd), .out_wr_en(out_wr_en),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush),
    .pending(pending), .inflight(inflight), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: samples just before each rising edge.
  always begin
    @(negedge clk);
    #4;
    if (!rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && flush) begin
        if (sb_q.size() > 0) exp_item = sb_q.pop_front();
      end else if (out_valid && out_ready) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected slot got=%b with empty queue",
                   {read_reg1, read_reg2, out_rd, out_wr_en});
        end else begin
          exp_item = sb_q.pop_front();
          if ({read_reg1, read_reg2, out_rd, out_wr_en} !== exp_item) begin
            n_fail++;
            $display("FAIL sb_slot got=%b exp=%b",
                     {read_reg1, read_reg2, out_rd, out_wr_en}, exp_item);
          end
        end
      end
      if (in_valid && in_ready) sb_q.push_back({in_rs1, in_rs2, in_rd, in_wr_en});
    end
  end

  task automatic offer(input logic v, input logic [1:0] rs1, input logic [1:0] rs2,
                       input logic [1:0] rd, input logic wr);
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_wr_en = wr;
  endtask

  task automatic idle(input int n);
    offer(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
    wb_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(2);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending got=%b exp=0000", pending); end
    n_tests++; if (inflight !== 2'd0) begin n_fail++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
    n_tests++; if (wb_err !== 1'b0) begin n_fail++; $display("FAIL reset_wb_err got=%b exp=0", wb_err); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    idle(1);
  endtask

  task automatic test_raw_bypass();
    offer(1'b1, 2'd0, 2'd0, 2'd1, 1'b1);
    @(negedge clk);
    offer(1'b1, 2'd1, 2'd0, 2'd0, 1'b0);
    #1;
    n_tests++; if (pending !== 4'b0010) begin n_fail++; $display("FAIL raw_pending_set got=%b exp=0010", pending); end
    n_tests++; if (inflight !== 2'd1) begin n_fail++; $display("FAIL raw_inflight got=%0d exp=1", inflight); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL raw_latency got=%b exp=1", out_valid); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall[%0d] got=%b exp=0", i, in_ready); end
      @(negedge clk);
    end
    wb_valid = 1'b1; wb_reg = 2'd1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_bypass_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    wb_valid = 1'b0; offer(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
    #1;
    n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL raw_pending_after_wb got=%b exp=0000", pending); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL raw_bypass_issue got=%b exp=1", out_valid); end
    idle(2);
  endtask

  task automatic test_max_pending();
    for (int r = 0; r < 3; r++) begin
      offer(1'b1, 2'd3, 2'd3, 2'(r), 1'b1);
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL max_fill_ready[%0d] got=%b exp=1", r, in_ready); end
      @(negedge clk);
    end
    offer(1'b1, 2'd3, 2'd3, 2'd3, 1'b1);
    #1;
    n_tests++; if (inflight !== 2'd3) begin n_fail++; $display("FAIL max_inflight got=%0d exp=3", inflight); end
    n_tests++; if (pending !== 4'b0111) begin n_fail++; $display("FAIL max_pending got=%b exp=0111", pending); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL max_full_stall got=%b exp=0", in_ready); end
    @(negedge clk);
    wb_valid = 1'b1; wb_reg = 2'd0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL max_wb_bypass got=%b exp=1", in_ready); end
    @(negedge clk);
    offer(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
    wb_valid = 1'b0;
    #1;
    n_tests++; if (inflight !== 2'd3) begin n_fail++; $display("FAIL max_inflight_net got=%0d exp=3", inflight); end
    n_tests++; if (pending !== 4'b1110) begin n_fail++; $display("FAIL max_pending_swap got=%b exp=1110", pending); end
    for (int r = 1; r < 4; r++) begin
      wb_valid = 1'b1; wb_reg = 2'(r);
      @(negedge clk);
    end
    wb_valid = 1'b0;
    #1;
    n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL max_drain_pending got=%b exp=0000", pending); end
    n_tests++; if (inflight !== 2'd0) begin n_fail++; $display("FAIL max_drain_inflight got=%0d exp=0", inflight); end
    n_tests++; if (wb_err !== 1'b0) begin n_fail++; $display("FAIL max_no_wb_err got=%b exp=0", wb_err); end
    idle(2);
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    offer(1'b1, 2'd1, 2'd2, 2'd0, 1'b0);
    @(negedge clk);
    offer(1'b1, 2'd3, 2'd0, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++; if ({out_valid, read_reg1, read_reg2} !== 5'b1_01_10) begin n_fail++; $display("FAIL stall_slot[%0d] got=%b exp=10110", i, {out_valid, read_reg1, read_reg2}); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got=%b exp=0", i, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    offer(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
    #1;
    n_tests++; if ({out_valid, read_reg1, read_reg2} !== 5'b1_11_00) begin n_fail++; $display("FAIL stall_next_slot got=%b exp=11100", {out_valid, read_reg1, read_reg2}); end
    idle(2);
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer(1'b1, 2'd0, 2'd0, 2'd2, 1'b1);
    @(negedge clk);
    offer(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
    #1;
    n_tests++; if (pending !== 4'b0100) begin n_fail++; $display("FAIL flush_pre_pending got=%b exp=0100", pending); end
    flush = 1'b1;
    offer(1'b1, 2'd0, 2'd0, 2'd1, 1'b1);
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_blocks_accept got=%b exp=0", in_ready); end
    @(negedge clk);
    flush = 1'b0;
    offer(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL flush_pending got=%b exp=0000", pending); end
    n_tests++; if (inflight !== 2'd0) begin n_fail++; $display("FAIL flush_inflight got=%0d exp=0", inflight); end
    n_tests++; if (wb_err !== 1'b0) begin n_fail++; $display("FAIL flush_wb_err got=%b exp=0", wb_err); end
    idle(1);
  endtask

  task automatic test_wb_err();
    wb_valid = 1'b1; wb_reg = 2'd3;
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    n_tests++; if (wb_err !== 1'b1) begin n_fail++; $display("FAIL wb_err_set got=%b exp=1", wb_err); end
    n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL wb_err_pending got=%b exp=0000", pending); end
    idle(3);
    #1;
    n_tests++; if (wb_err !== 1'b1) begin n_fail++; $display("FAIL wb_err_sticky got=%b exp=1", wb_err); end
  endtask

  task automatic test_flush_wb_same();
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    out_ready = 1'b0;
    offer(1'b1, 2'd0, 2'd0, 2'd1, 1'b1);
    @(negedge clk);
    offer(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
    flush = 1'b1; wb_valid = 1'b1; wb_reg = 2'd1;
    @(negedge clk);
    flush = 1'b0; wb_valid = 1'b0;
    #1;
    n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL fwb_pending got=%b exp=0000", pending); end
    n_tests++; if (inflight !== 2'd0) begin n_fail++; $display("FAIL fwb_inflight got=%0d exp=0", inflight); end
    n_tests++; if (wb_err !== 1'b1) begin n_fail++; $display("FAIL fwb_wb_err got=%b exp=1", wb_err); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fwb_out_valid got=%b exp=0", out_valid); end
    idle(1);
  endtask

  task automatic test_async_reset();
    offer(1'b1, 2'd0, 2'd0, 2'd1, 1'b1);
    @(negedge clk);
    offer(1'b1, 2'd3, 2'd0, 2'd2, 1'b1);
    @(negedge clk);
    offer(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
    out_ready = 1'b0;
    #1;
    n_tests++; if (pending !== 4'b0110) begin n_fail++; $display("FAIL arst_pre_pending got=%b exp=0110", pending); end
    n_tests++; if ({out_valid, read_reg1, out_rd, out_wr_en} !== 6'b1_11_10_1) begin n_fail++; $display("FAIL arst_pre_slot got=%b exp=111101", {out_valid, read_reg1, out_rd, out_wr_en}); end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_tests++; if ({out_valid, read_reg1, read_reg2, out_rd, out_wr_en} !== 8'd0) begin n_fail++; $display("FAIL arst_slot got=%b exp=00000000", {out_valid, read_reg1, read_reg2, out_rd, out_wr_en}); end
    n_tests++; if ({pending, inflight, wb_err} !== 7'd0) begin n_fail++; $display("FAIL arst_state got=%b exp=0000000", {pending, inflight, wb_err}); end
    @(negedge clk);
    rst = 1'b1;
    idle(2);
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_wr_en = 1'b0;
    out_ready = 1'b1; wb_valid = 1'b0; wb_reg = '0; flush = 1'b0;
    test_reset();
    test_raw_bypass();
    test_max_pending();
    test_stall();
    test_flush();
    test_wb_err();
    test_flush_wb_same();
    test_async_reset();
    n_tests++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
